sdram_init_seq: RTL and testbench
=================================

Name: sdram_init_seq

Overview:
- SDRAM power-up initialization sequencer. It drives the SDRAM command bus from reset until the device is ready.
- Order of operations: NOP wait, PRECHARGE-ALL, N AUTO REFRESH commands, LOAD MODE REGISTER, then raise sdr_init_done.
- Sits between the controller's reset/config registers and the SDRAM command mux. The main request FSM takes the bus only after sdr_init_done is high.
- All intervals are parameterized cycle counts and are checked cycle-exactly by the init assertions.

Parameters:
- INIT_WAIT, 10000: NOP cycles before PRECHARGE (100 us at 100 MHz).
- T_RP, 8: cycles from PRECHARGE to first AUTO REFRESH.
- T_RFC, 10: cycles between consecutive AUTO REFRESH commands, and from the last refresh to LOAD MODE.
- REFRESH_CNT, 16: number of AUTO REFRESH commands (>=1).
- T_MRD, 18: cycles from LOAD MODE to sdr_init_done.
- ADDR_W, 13: SDRAM address width (>=11).

Ports:
- sys_clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- cfg_sdr_cas, in, 3: CAS latency for mode register A[6:4].
- cfg_sdr_bl, in, 3: burst length code for A[2:0].
- cfg_sdr_bt, in, 1: burst type for A3.
- cfg_sdr_wbm, in, 1: write burst mode for A9.
- sdr_cke, out, 1: clock enable.
- sdr_cs_n, out, 1: chip select, active-low.
- sdr_ras_n, out, 1: row strobe, active-low.
- sdr_cas_n, out, 1: column strobe, active-low.
- sdr_we_n, out, 1: write enable, active-low.
- sdr_ba, out, 2: bank address.
- sdr_addr, out, ADDR_W: address bus.
- sdr_init_done, out, 1: initialization complete, sticky until reset.
- init_busy, out, 1: sequence in progress.

Behaviour:
- Reset and clocking: one clock (sys_clk); reset is synchronous, active-high. All outputs are registered.
- Values while reset is high (and in the cycle after):
  - sdr_cke=0.
  - cs_n/ras_n/cas_n/we_n = 1111 (COMMAND INHIBIT).
  - ba=0, addr=0.
  - sdr_init_done=0, init_busy=0.
- Cycle numbering: cycle 0 is the first rising edge with reset low.
- From cycle 0:
  - sdr_cke=1 and stays 1.
  - init_busy=1 until sdr_init_done rises.
- Command encoding {cs_n,ras_n,cas_n,we_n}:
  - NOP=0111
  - PRECHARGE=0010
  - AUTO_REFRESH=0001
  - LOAD_MODE=0000
  - INHIBIT=1111 (reset only)
- Command schedule. Each command is driven for exactly one cycle; every other cycle is NOP with addr=0 and ba=0.
  - Cycles 0..INIT_WAIT-1: NOP.
  - Cycle P=INIT_WAIT: PRECHARGE, addr[10]=1 (all banks), other addr bits 0, ba=0.
  - Cycle R_k = P + T_RP + k*T_RFC, for k=0..REFRESH_CNT-1: AUTO_REFRESH.
  - Cycle M = R_last + T_RFC: LOAD_MODE, ba=0, and:
    - addr[2:0] = cfg_sdr_bl
    - addr[3] = cfg_sdr_bt
    - addr[6:4] = cfg_sdr_cas
    - addr[8:7] = 0
    - addr[9] = cfg_sdr_wbm
    - addr[ADDR_W-1:10] = 0
- Config sampling: cfg_* are sampled in the cycle the LOAD_MODE command is registered. Changes at any other time have no effect. cfg_sdr_cas is encoded verbatim, with no legality check.
- Completion:
  - Cycle M+T_MRD: sdr_init_done=1 and init_busy=0.
  - From then, commands are NOP forever until reset.
- State machine:
  - WAIT → PRE → TRP → REF → TRFC → (REF again while refresh count < REFRESH_CNT, otherwise LMR) → TMRD → DONE.
  - One shared down-counter is loaded on each state entry with (interval-1), so spacing is exact.
  - A separate refresh counter has width $clog2(REFRESH_CNT+1).
  - The shared counter's width is $clog2(max of all intervals).
- Boundaries:
  - reset asserted in any state → INHIBIT output next cycle; the sequence restarts from cycle 0 after release.
  - REFRESH_CNT=1 → LOAD_MODE at P+T_RP+T_RFC.
  - Intervals of 1 → back-to-back commands, with no NOP in between.
  - sdr_init_done never deasserts without reset.

Decomposition:
- Shared package sdram_init_pkg holds:
  - sdr_cmd_t: 4-bit enum of the command encodings above.
  - init_state_t: the state enum.
  - Mode-register bit-position localparams (BL_LSB, BT_BIT, CAS_LSB, WBM_BIT).
- One sub-module, sdram_init_timer: loadable down-counter (load, value, zero flag), parameter CNT_W.

Test Plan (test parameters: INIT_WAIT=20, T_RP=8, T_RFC=10, REFRESH_CNT=2, T_MRD=18, ADDR_W=13):
- Release reset at cycle 0 → NOP (0111) for cycles 0..19 and cke=1 from cycle 0.
- Check command timing after release:
  - cycle 20: PRECHARGE with addr=0x400.
  - cycles 28 and 38: AUTO_REFRESH.
  - cycle 48: LOAD_MODE.
  - cycle 66: sdr_init_done=1 and init_busy=0.
- cfg_sdr_cas=3, bl=3, bt=0, wbm=1 → LOAD_MODE addr=0x233, ba=0.
- Change cfg_sdr_cas 2→3 at cycle 30, bl=0, bt=0, wbm=0 → LOAD_MODE addr=0x030. Change cfg_sdr_cas at cycle 50 → no effect.
- Assert reset at cycle 33 (during TRFC) → next cycle outputs INHIBIT, cke=0, init_done=0. After release, PRECHARGE again occurs exactly 20 cycles later.
- Run to 2000 cycles after done → sdr_init_done stays 1 and bus stays NOP.

Source files
------------

// File: rtl/sdram_init_pkg.sv
// sdram_init_pkg: shared command encodings, FSM states and mode-register bit positions
package sdram_init_pkg;
  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_NOP = 4'b0111,
    CMD_INH = 4'b1111
  } sdr_cmd_t;
  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT, ST_PRE, ST_TRP, ST_REF, ST_TRFC, ST_LMR, ST_TMRD, ST_DONE
  } init_state_t;
  localparam int BL_LSB  = 0;
  localparam int BT_BIT  = 3;
  localparam int CAS_LSB = 4;
  localparam int WBM_BIT = 9;
  function automatic sdr_cmd_t cmd_of(init_state_t s);
    return s == ST_PRE ? CMD_PRE : s == ST_REF ? CMD_REF : s == ST_LMR ? CMD_LMR : CMD_NOP;
  endfunction
endpackage

// File: rtl/sdram_init_timer.sv
// sdram_init_timer: loadable saturating down-counter with zero flag
module sdram_init_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  // load on command issue, otherwise count down and hold at zero
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDRAM power-up sequencer (NOP wait, precharge-all, auto refreshes, load mode)
module sdram_init_seq
  import sdram_init_pkg::*;
#(
  parameter int INIT_WAIT   = 10000,
  parameter int T_RP        = 8,
  parameter int T_RFC       = 10,
  parameter int REFRESH_CNT = 16,
  parameter int T_MRD       = 18,
  parameter int ADDR_W      = 13
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [2:0]        cfg_sdr_cas,
  input  logic [2:0]        cfg_sdr_bl,
  input  logic              cfg_sdr_bt,
  input  logic              cfg_sdr_wbm,
  output logic              sdr_cke,
  output logic              sdr_cs_n,
  output logic              sdr_ras_n,
  output logic              sdr_cas_n,
  output logic              sdr_we_n,
  output logic [1:0]        sdr_ba,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic              sdr_init_done,
  output logic              init_busy
);
  localparam int MAX_A  = INIT_WAIT > T_RP ? INIT_WAIT : T_RP;
  localparam int MAX_B  = T_RFC > T_MRD ? T_RFC : T_MRD;
  localparam int MAX_IV = MAX_A > MAX_B ? MAX_A : MAX_B;
  localparam int CNT_W  = $clog2(MAX_IV) > 0 ? $clog2(MAX_IV) : 1;
  localparam int RC_W   = $clog2(REFRESH_CNT + 1);
  init_state_t       state, nxt;
  sdr_cmd_t          cmd_q;
  logic [RC_W-1:0]   ref_cnt;
  logic [CNT_W-1:0]  load_val;
  logic [ADDR_W-1:0] mode, pre_addr;
  logic              zero, load;
  sdram_init_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (sys_clk),
    .rst  (reset),
    .load (load),
    .value(load_val),
    .zero (zero)
  );
  // next state: each command state or its wait state advances when the shared timer expires
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:         nxt = ST_WAIT;
      ST_WAIT:         nxt = zero ? ST_PRE : ST_WAIT;
      ST_PRE, ST_TRP:  nxt = zero ? ST_REF : ST_TRP;
      ST_REF, ST_TRFC: nxt = zero ? (ref_cnt < RC_W'(REFRESH_CNT) ? ST_REF : ST_LMR) : ST_TRFC;
      ST_LMR, ST_TMRD: nxt = zero ? ST_DONE : ST_TMRD;
      default:         nxt = ST_DONE;
    endcase
  end
  // a timer load marks entry into a new phase; the loaded interval belongs to that phase
  always_comb begin
    load     = state == ST_IDLE || (zero && state != ST_DONE);
    load_val = nxt == ST_WAIT ? CNT_W'(INIT_WAIT - 1) :
               nxt == ST_PRE  ? CNT_W'(T_RP - 1) :
               nxt == ST_REF  ? CNT_W'(T_RFC - 1) : CNT_W'(T_MRD - 1);
  end
  // mode-register word from live config, and the all-banks precharge address
  always_comb begin
    mode              = '0;
    mode[BL_LSB+:3]   = cfg_sdr_bl;
    mode[BT_BIT]      = cfg_sdr_bt;
    mode[CAS_LSB+:3]  = cfg_sdr_cas;
    mode[WBM_BIT]     = cfg_sdr_wbm;
    pre_addr          = '0;
    pre_addr[10]      = 1'b1;
  end
  // state, refresh count and registered command bus
  always_ff @(posedge sys_clk)
    if (reset) begin
      state         <= ST_IDLE;
      ref_cnt       <= '0;
      cmd_q         <= CMD_INH;
      sdr_cke       <= 1'b0;
      sdr_addr      <= '0;
      sdr_init_done <= 1'b0;
      init_busy     <= 1'b0;
    end else begin
      state         <= nxt;
      ref_cnt       <= load && nxt == ST_REF ? ref_cnt + RC_W'(1) : ref_cnt;
      cmd_q         <= load ? cmd_of(nxt) : CMD_NOP;
      sdr_cke       <= 1'b1;
      sdr_addr      <= load && nxt == ST_PRE ? pre_addr : load && nxt == ST_LMR ? mode : '0;
      sdr_init_done <= nxt == ST_DONE;
      init_busy     <= nxt != ST_DONE;
    end
  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
  assign sdr_ba = 2'b00;
endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq: directed checks of the init command schedule, config sampling and reset restart
module tb_sdram_init_seq;
  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  cfg_sdr_cas = 3'd3;
  logic [2:0]  cfg_sdr_bl = 3'd3;
  logic        cfg_sdr_bt = 1'b0;
  logic        cfg_sdr_wbm = 1'b1;
  logic        sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [1:0]  sdr_ba;
  logic [12:0] sdr_addr;
  logic        sdr_init_done, init_busy;
  int          n_cmp = 0;
  int          n_err = 0;
  sdram_init_seq #(
    .INIT_WAIT(20), .T_RP(8), .T_RFC(10), .REFRESH_CNT(2), .T_MRD(18), .ADDR_W(13)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .cfg_sdr_cas  (cfg_sdr_cas),
    .cfg_sdr_bl   (cfg_sdr_bl),
    .cfg_sdr_bt   (cfg_sdr_bt),
    .cfg_sdr_wbm  (cfg_sdr_wbm),
    .sdr_cke      (sdr_cke),
    .sdr_cs_n     (sdr_cs_n),
    .sdr_ras_n    (sdr_ras_n),
    .sdr_cas_n    (sdr_cas_n),
    .sdr_we_n     (sdr_we_n),
    .sdr_ba       (sdr_ba),
    .sdr_addr     (sdr_addr),
    .sdr_init_done(sdr_init_done),
    .init_busy    (init_busy)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask
  function automatic logic [3:0] bus();
    return {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
  endfunction
  task automatic check_inhibit(input string tag);
    check({tag, "_cmd"}, 32'(bus()), 32'hf);
    check({tag, "_addr"}, 32'(sdr_addr), 32'h0);
    check({tag, "_flags"}, 32'({sdr_cke, sdr_ba, sdr_init_done, init_busy}), 32'h0);
  endtask
  // reset release schedule: PRE@20, REF@28,38, LMR@48, done from 66
  task automatic run(input int n, input logic [12:0] mode, input bit cfg_change);
    for (int c = 0; c < n; c++) begin
      logic [3:0]  e_cmd;
      logic [12:0] e_addr;
      step();
      e_cmd  = c == 20 ? 4'b0010 : (c == 28 || c == 38) ? 4'b0001 : c == 48 ? 4'b0000 : 4'b0111;
      e_addr = c == 20 ? 13'h400 : c == 48 ? mode : 13'h0;
      check($sformatf("cmd_c%0d", c), 32'(bus()), 32'(e_cmd));
      check($sformatf("addr_c%0d", c), 32'(sdr_addr), 32'(e_addr));
      check($sformatf("flags_c%0d", c), 32'({sdr_cke, sdr_ba, sdr_init_done, init_busy}),
            32'({1'b1, 2'b00, c >= 66, c < 66}));
      if (cfg_change && c == 30) cfg_sdr_cas = 3'd3;
      if (cfg_change && c == 50) cfg_sdr_cas = 3'd5;
    end
  endtask
  initial begin
    repeat (3) step();
    check_inhibit("reset");
    reset = 1'b0;
    run(71, 13'h233, 1'b0);
    for (int c = 0; c < 2000; c++) begin
      step();
      check("post_done_cmd", 32'(bus()), 32'h7);
      check("post_done_state", 32'({sdr_addr, sdr_init_done, init_busy}), 32'({13'h0, 2'b10}));
    end
    reset = 1'b1;
    cfg_sdr_cas = 3'd2;
    cfg_sdr_bl = 3'd0;
    cfg_sdr_bt = 1'b0;
    cfg_sdr_wbm = 1'b0;
    step();
    check_inhibit("reset_after_done");
    reset = 1'b0;
    run(71, 13'h030, 1'b1);
    reset = 1'b1;
    cfg_sdr_cas = 3'd2;
    cfg_sdr_bl = 3'd7;
    cfg_sdr_bt = 1'b1;
    cfg_sdr_wbm = 1'b0;
    step();
    reset = 1'b0;
    run(33, 13'h02f, 1'b0);
    reset = 1'b1;
    step();
    check_inhibit("reset_mid_trfc");
    reset = 1'b0;
    run(71, 13'h02f, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
